// File: rtl/order_pkg.sv
// Shared types for the order ingress path: queued order entry and sequencer state.
package order_pkg;

  localparam int CLIENT_W_DEF = 5;
  localparam int AMT_W_DEF    = 16;

  typedef struct packed {
    logic [CLIENT_W_DEF-1:0] client_id;
    logic [AMT_W_DEF-1:0]    amount;
    logic                    is_max;
  } order_entry_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} ingress_state_e;

endpackage

// File: rtl/order_fifo.sv
// Synchronous FIFO with combinational read of the head entry.
// The caller never pushes when full nor pops when empty.
module order_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 22
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]              count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset; stale contents are never read because count gates pops.
  always_ff @(posedge clk) mem_q <= mem_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/order_ingress_sequencer.sv
// Queues client orders and presents them one at a time to the risk stage, holding
// each until done or timeout, then inserting a one-cycle gap between requests.
module order_ingress_sequencer
  import order_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int CLIENT_W = CLIENT_W_DEF,
  parameter int AMT_W    = AMT_W_DEF,
  parameter int TIMEOUT  = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CLIENT_W-1:0]    in_client_id,
  input  logic [AMT_W-1:0]       in_amount,
  input  logic                   in_is_max,
  input  logic                   stage_done,
  output logic [CLIENT_W-1:0]    out_client_id,
  output logic [AMT_W-1:0]       out_amount,
  output logic                   out_new_order,
  output logic                   out_new_max,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             timeout_cnt
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [CLIENT_W-1:0] client_id;
    logic [AMT_W-1:0]    amount;
    logic                is_max;
  } entry_t;

  entry_t wr_entry, rd_entry;
  logic   push, pop;

  ingress_state_e      state_q, state_d;
  logic [7:0]          wait_cnt_q, wait_cnt_d;
  logic [7:0]          timeout_cnt_q, timeout_cnt_d;
  logic [CLIENT_W-1:0] out_client_id_q, out_client_id_d;
  logic [AMT_W-1:0]    out_amount_q, out_amount_d;
  logic                new_order_q, new_order_d;
  logic                new_max_q, new_max_d;
  logic                busy_q, busy_d;

  // Ready looks only at the registered occupancy, never at a same-cycle pop.
  assign in_ready = (count < CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign wr_entry = '{client_id: in_client_id, amount: in_amount, is_max: in_is_max};

  order_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (rd_entry),
    .count   (count)
  );

  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    timeout_cnt_d   = timeout_cnt_q;
    out_client_id_d = out_client_id_q;
    out_amount_d    = out_amount_q;
    new_order_d     = new_order_q;
    new_max_d       = new_max_q;
    pop             = 1'b0;
    case (state_q)
      IDLE: begin
        if (count != '0) begin
          state_d         = ISSUE;
          pop             = 1'b1;
          out_client_id_d = rd_entry.client_id;
          out_amount_d    = rd_entry.amount;
          new_order_d     = !rd_entry.is_max;
          new_max_d       = rd_entry.is_max;
          wait_cnt_d      = '0;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        wait_cnt_d = wait_cnt_q + 8'd1;
        if (stage_done || wait_cnt_q == 8'(TIMEOUT - 1)) begin
          state_d     = GAP;
          new_order_d = 1'b0;
          new_max_d   = 1'b0;
          // A coincident done wins over the timeout and is not counted.
          if (!stage_done && timeout_cnt_q != 8'hFF)
            timeout_cnt_d = timeout_cnt_q + 8'd1;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      wait_cnt_q      <= '0;
      timeout_cnt_q   <= '0;
      out_client_id_q <= '0;
      out_amount_q    <= '0;
      new_order_q     <= 1'b0;
      new_max_q       <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      wait_cnt_q      <= wait_cnt_d;
      timeout_cnt_q   <= timeout_cnt_d;
      out_client_id_q <= out_client_id_d;
      out_amount_q    <= out_amount_d;
      new_order_q     <= new_order_d;
      new_max_q       <= new_max_d;
      busy_q          <= busy_d;
    end
  end

  assign out_client_id = out_client_id_q;
  assign out_amount    = out_amount_q;
  assign out_new_order = new_order_q;
  assign out_new_max   = new_max_q;
  assign busy          = busy_q;
  assign timeout_cnt   = timeout_cnt_q;

endmodule

// File: tb/tb_order_ingress_sequencer.sv
// Randomized bench: a transaction-level model (order queue plus cycles-since-issue
// counter) predicts every output each cycle.
module tb_order_ingress_sequencer;
  import order_pkg::*;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_is_max, stage_done;
  logic [4:0]  in_client_id;
  logic [15:0] in_amount;
  logic        in_ready, out_new_order, out_new_max, busy;
  logic [4:0]  out_client_id;
  logic [15:0] out_amount;
  logic [3:0]  count;
  logic [7:0]  timeout_cnt;

  always #5 clk = ~clk;

  order_ingress_sequencer #(
    .DEPTH(DEPTH), .CLIENT_W(5), .AMT_W(16), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_client_id(in_client_id), .in_amount(in_amount), .in_is_max(in_is_max),
    .stage_done(stage_done), .out_client_id(out_client_id), .out_amount(out_amount),
    .out_new_order(out_new_order), .out_new_max(out_new_max), .busy(busy),
    .count(count), .timeout_cnt(timeout_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Model: waiting orders, the order in flight, cycles since it was issued
  // (-1 = nothing in flight), whether the one-cycle gap is in progress.
  order_entry_t q[$];
  order_entry_t cur;
  int           age;
  bit           gap;
  int           tcnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    bit act;
    act = (age >= 0) && !gap;
    chk("busy",      32'(busy),          32'(age >= 0));
    chk("count",     32'(count),         32'(q.size()));
    chk("in_ready",  32'(in_ready),      32'(q.size() < DEPTH));
    chk("new_order", 32'(out_new_order), 32'(act && !cur.is_max));
    chk("new_max",   32'(out_new_max),   32'(act && cur.is_max));
    chk("client_id", 32'(out_client_id), 32'(cur.client_id));
    chk("amount",    32'(out_amount),    32'(cur.amount));
    chk("tmo_cnt",   32'(timeout_cnt),   32'(tcnt));
  endtask

  task automatic drive(input int vp, input int dp, input int rp);
    rst          = ($urandom_range(99) < rp);
    in_valid     = ($urandom_range(99) < vp);
    in_client_id = 5'($urandom);
    in_amount    = 16'($urandom);
    in_is_max    = 1'($urandom_range(1));
    stage_done   = ($urandom_range(99) < dp);
  endtask

  task automatic step();
    bit           ready;
    order_entry_t e;
    ready = (q.size() < DEPTH);
    if (rst) begin
      q.delete();
      cur  = '0;
      age  = -1;
      gap  = 1'b0;
      tcnt = 0;
    end else begin
      if (age < 0) begin
        if (q.size() > 0) begin
          cur = q.pop_front();
          age = 0;
          gap = 1'b0;
        end
      end else if (gap) begin
        age = -1;
        gap = 1'b0;
      end else if (age == 0) begin
        age = 1;
      end else if (stage_done || age == TIMEOUT) begin
        if (!stage_done && tcnt < 255) tcnt++;
        gap = 1'b1;
      end else begin
        age++;
      end
      if (in_valid && ready) begin
        e.client_id = in_client_id;
        e.amount    = in_amount;
        e.is_max    = in_is_max;
        q.push_back(e);
      end
    end
  endtask

  task automatic run(input int n, input int vp, input int dp, input int rp);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_all();
      drive(vp, dp, rp);
      @(posedge clk);
      step();
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_is_max = 1'b0; stage_done = 1'b0;
    in_client_id = '0; in_amount = '0;
    repeat (2) begin
      @(posedge clk);
      step();
    end
    run(200,  40,  50, 0);   // mixed traffic
    run(300,  90,   0, 0);   // fill to full, timeouts only
    run(400,  80, 100, 0);   // done on first WAIT cycle, pointer wrap
    run(4500, 50,   0, 0);   // enough timeouts to saturate the counter
    chk("tmo_sat", 32'(timeout_cnt), 32'd255);
    run(1500, 50,  30, 3);   // random resets mid-flight
    @(negedge clk);
    check_all();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
